stream_reader: RTL and testbench

STREAM_READER -- requirements
Module: stream_reader

---
 rtl/stream_reader_if.sv | 57 +++++
 rtl/stream_reader.sv | 180 ++++++++++++++++++
 tb/tb_stream_reader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_reader_if.sv
// -----------------------------------------------------------------------------
// stream_reader_if
//   Bundles the two buses of stream_reader: the IceRam read port and the
//   valid/ready output stream.
//
//   RAM side
//     ramAddress        address presented to the IceRam
//     ramReadWriteMode  IceRam mode (0 = read)
//     ramDataOut        IceRam read data, valid the cycle after its address
//   Stream side
//     outValid / outReady  handshake; a word moves when both are high
//     outData              streamed word
//     outLast              marks the final word of a block
//
//   Modports
//     master  the reader (drives address, mode and the stream)
//     slave   the environment (RAM and consumer)
// -----------------------------------------------------------------------------
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

interface stream_reader_if #(
    parameter int addrBits = `ADDRESS_BITS,
    parameter int dataBits = `DATA_BITS
);
    logic [addrBits-1:0] ramAddress;
    logic                ramReadWriteMode;
    logic [dataBits-1:0] ramDataOut;
    logic                outValid;
    logic                outReady;
    logic [dataBits-1:0] outData;
    logic                outLast;

    modport master (
        output ramAddress,
        output ramReadWriteMode,
        input  ramDataOut,
        output outValid,
        input  outReady,
        output outData,
        output outLast
    );

    modport slave (
        input  ramAddress,
        input  ramReadWriteMode,
        output ramDataOut,
        input  outValid,
        output outReady,
        input  outData,
        input  outLast
    );
endinterface

// File: rtl/stream_reader.sv
// -----------------------------------------------------------------------------
// stream_reader
//   Reads a block of consecutive words from an IceRam (one-cycle read
//   latency) and streams them out over a valid/ready interface, with a
//   2-entry output FIFO absorbing consumer back-pressure.
//
//   Ports
//     clk            sole clock
//     reset          synchronous, active-high
//     start          one-cycle request to read a block (ignored while busy)
//     startAddress   first RAM address of the block
//     numberOfWords  block length; 0 completes immediately
//     busy           high while streaming
//     finished       high once a block has completed, until the next start
//     bus            RAM read port and output stream (stream_reader_if.master)
// -----------------------------------------------------------------------------
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module stream_reader #(
    parameter int addrBits = `ADDRESS_BITS,
    parameter int dataBits = `DATA_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addrBits-1:0] startAddress,
    input  logic [addrBits-1:0] numberOfWords,
    output logic                busy,
    output logic                finished,
    stream_reader_if.master     bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [addrBits-1:0] ONE = {{(addrBits-1){1'b0}}, 1'b1};

    logic [1:0]          state_q, state_d;
    logic [addrBits-1:0] next_addr_q, next_addr_d;   // address of the next read
    logic [addrBits-1:0] last_addr_q, last_addr_d;   // address held between reads
    logic [addrBits-1:0] issue_rem_q, issue_rem_d;   // reads still to issue
    logic [addrBits-1:0] deliv_rem_q, deliv_rem_d;   // words still to deliver
    logic                rd_pend_q, rd_pend_d;       // RAM data arrives this cycle
    logic [1:0]          cnt_q, cnt_d;               // FIFO occupancy
    logic [dataBits-1:0] head_q, head_d;             // FIFO head (presented)
    logic [dataBits-1:0] tail_q, tail_d;             // FIFO second entry

    logic                start_ok;
    logic                out_valid;
    logic                pop;
    logic                push;
    logic                issue;
    logic [2:0]          fill_after;

    always_comb begin
        start_ok  = start && (state_q != STREAM);
        out_valid = (cnt_q != 2'd0);
        pop       = out_valid && bus.outReady;
        push      = rd_pend_q;

        // Occupancy after this cycle's push/pop. Counting the pop lets a new
        // read go out in the same cycle a word leaves, which is what sustains
        // one word per cycle; the read issued now is then the only one still
        // in flight, so occupancy plus in-flight never exceeds two.
        fill_after = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, push};
        issue      = (state_q == STREAM) && (issue_rem_q != '0) &&
                     (fill_after < 3'd2);

        // Control state
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (numberOfWords == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (pop && (deliv_rem_q == ONE)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Address generation and remaining-word counters
        next_addr_d = next_addr_q;
        last_addr_d = last_addr_q;
        issue_rem_d = issue_rem_q;
        deliv_rem_d = deliv_rem_q;
        if (start_ok) begin
            next_addr_d = startAddress;
            issue_rem_d = numberOfWords;
            deliv_rem_d = numberOfWords;
        end else begin
            if (issue) begin
                next_addr_d = next_addr_q + ONE;   // wraps modulo 2^addrBits
                last_addr_d = next_addr_q;
                issue_rem_d = issue_rem_q - ONE;
            end
            if (pop) begin
                deliv_rem_d = deliv_rem_q - ONE;
            end
        end

        // The IceRam returns data one cycle after the address is presented
        rd_pend_d = issue;

        // 2-entry FIFO; head is always the oldest word
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = bus.ramDataOut;
                end else begin
                    tail_d = bus.ramDataOut;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the returning word queues behind
                // whatever remains after the pop.
                if (cnt_q == 2'd1) begin
                    head_d = bus.ramDataOut;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.ramDataOut;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            last_addr_q <= '0;
            issue_rem_q <= '0;
            deliv_rem_q <= '0;
            rd_pend_q   <= 1'b0;
            cnt_q       <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            last_addr_q <= last_addr_d;
            issue_rem_q <= issue_rem_d;
            deliv_rem_q <= deliv_rem_d;
            rd_pend_q   <= rd_pend_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    // The read address goes out in the issuing cycle; otherwise the previous
    // address is held so the RAM inputs stay quiet.
    assign bus.ramAddress       = issue ? next_addr_q : last_addr_q;
    assign bus.ramReadWriteMode = 1'b0;
    assign bus.outValid         = out_valid;
    assign bus.outData          = head_q;
    assign bus.outLast          = out_valid && (deliv_rem_q == ONE);

    assign busy     = (state_q == STREAM);
    assign finished = (state_q == DONE);

endmodule

// File: tb/tb_stream_reader.sv
module tb_stream_reader;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] startAddress;
    logic [AW-1:0] numberOfWords;
    logic          busy;
    logic          finished;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [DW-1:0] ram [256];

    stream_reader_if #(.addrBits(AW), .dataBits(DW)) bus ();

    stream_reader #(.addrBits(AW), .dataBits(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .startAddress  (startAddress),
        .numberOfWords (numberOfWords),
        .busy          (busy),
        .finished      (finished),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // IceRam model: registered read, data valid the cycle after the address
    always @(posedge clk) bus.ramDataOut <= ram[bus.ramAddress];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reads one block and compares the stream with the words the RAM holds at
    // startAddress, startAddress+1, ... (mod 256).
    // mode 0: outReady always 1; mode 1: 1,0,0 repeating; mode 2: random.
    task automatic run_block(input string tag, input logic [AW-1:0] sa,
                             input logic [AW-1:0] n, input int mode, input bit mid_start);
        logic [DW-1:0] expq[$];
        logic [DW-1:0] held;
        logic [AW-1:0] a;
        int            idx;
        int            first_v;
        int            budget;
        bit            stalled;
        bit            rw_bad;

        idx     = 0;
        first_v = -1;
        stalled = 1'b0;
        rw_bad  = 1'b0;
        held    = '0;
        for (int i = 0; i < int'(n); i++) begin
            a = sa + AW'(i);
            expq.push_back(ram[a]);
        end
        budget = 20 + 12 * int'(n);

        startAddress  = sa;
        numberOfWords = n;
        start         = 1'b1;
        bus.outReady  = 1'b0;
        tick();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(busy), 32'(n != '0));
        chk({tag, "_finished_after_start"}, 32'(finished), 32'(n == '0));

        for (int c = 1; c <= budget && idx < int'(n); c++) begin
            if (mid_start && c == 2) begin
                start         = 1'b1;
                startAddress  = sa + 8'h40;
                numberOfWords = n + 8'd3;
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       bus.outReady = 1'b1;
                1:       bus.outReady = ((c - 1) % 3 == 0);
                default: bus.outReady = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (bus.ramReadWriteMode !== 1'b0) rw_bad = 1'b1;
            if (mode == 0 && c <= int'(n)) begin
                a = sa + AW'(c - 1);
                chk({tag, "_ramAddress"}, 32'(bus.ramAddress), 32'(a));
            end
            if (stalled) begin
                chk({tag, "_stall_valid"}, 32'(bus.outValid), 32'd1);
                chk({tag, "_stall_data"}, 32'(bus.outData), 32'(held));
            end
            if (bus.outValid === 1'b1) begin
                if (first_v < 0) first_v = c;
                chk({tag, "_outLast"}, 32'(bus.outLast), 32'(idx == int'(n) - 1));
                if (bus.outReady) begin
                    chk({tag, "_data"}, 32'(bus.outData), 32'(expq[idx]));
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = bus.outData;
                end
            end else begin
                stalled = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        bus.outReady = 1'b0;

        chk({tag, "_word_count"}, 32'(idx), 32'(n));
        chk({tag, "_rw_mode_read"}, 32'(rw_bad), 32'd0);
        if (mode == 0 && n != '0) chk({tag, "_first_valid_cycle"}, 32'(first_v), 32'd3);
        #1;
        chk({tag, "_finished_at_end"}, 32'(finished), 32'd1);
        chk({tag, "_busy_at_end"}, 32'(busy), 32'd0);
        chk({tag, "_valid_at_end"}, 32'(bus.outValid), 32'd0);
        tick();
        chk({tag, "_finished_held"}, 32'(finished), 32'd1);
    endtask

    initial begin
        bit            got;
        logic [DW-1:0] first_exp;

        for (int i = 0; i < 256; i++) ram[i] = DW'($urandom);

        reset         = 1'b1;
        start         = 1'b0;
        startAddress  = '0;
        numberOfWords = '0;
        bus.outReady  = 1'b0;
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_finished", 32'(finished), 32'd0);
        chk("reset_outValid", 32'(bus.outValid), 32'd0);
        chk("reset_outLast", 32'(bus.outLast), 32'd0);
        chk("reset_outData", 32'(bus.outData), 32'd0);
        chk("reset_ramAddress", 32'(bus.ramAddress), 32'd0);
        chk("reset_rw_mode", 32'(bus.ramReadWriteMode), 32'd0);
        reset = 1'b0;
        tick();

        // Zero-length block straight from IDLE
        chk("zero_finished_before", 32'(finished), 32'd0);
        run_block("zero", 8'h10, 8'd0, 0, 1'b0);
        got = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.outReady = 1'b1;
            #1;
            if (bus.outValid !== 1'b0) got = 1'b1;
            tick();
        end
        bus.outReady = 1'b0;
        chk("zero_never_valid", 32'(got), 32'd0);

        run_block("basic", 8'h70, 8'd3, 0, 1'b0);
        run_block("toggle", 8'h70, 8'd3, 1, 1'b0);
        run_block("wrap", 8'hFE, 8'd3, 0, 1'b0);
        run_block("midstart", 8'h50, 8'd4, 0, 1'b1);

        // Reset in the middle of a 5-word block, right after the first word
        startAddress  = 8'h20;
        numberOfWords = 8'd5;
        first_exp     = ram[8'h20];
        start         = 1'b1;
        tick();
        start = 1'b0;
        got   = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            bus.outReady = 1'b1;
            #1;
            if (bus.outValid === 1'b1) begin
                got = 1'b1;
                chk("rst_first_word", 32'(bus.outData), 32'(first_exp));
            end
            tick();
        end
        chk("rst_first_word_seen", 32'(got), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_outValid", 32'(bus.outValid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finished", 32'(finished), 32'd0);
        chk("rst_outLast", 32'(bus.outLast), 32'd0);
        got = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.outValid !== 1'b0) got = 1'b1;
        end
        bus.outReady = 1'b0;
        chk("rst_quiet", 32'(got), 32'd0);
        run_block("after_rst", 8'h30, 8'd2, 0, 1'b0);

        // Randomised blocks with random back-pressure
        for (int k = 0; k < 8; k++) begin
            run_block("rand", AW'($urandom), AW'($urandom_range(1, 9)), 2, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
